stroke_point_replayer: RTL and testbench

- Source end of the 5-bit point stream consumed by the gesture resampler datapath.
- Captures one raw stroke (x,y points) into an internal buffer.
- At stroke end, replays the buffer twice as a back-to-back valid stream:
  - Pass 1 feeds the curve-length accumulator.
  - Pass 2 feeds the resample-point stage, with the latched total length held stable.

---
 rtl/stroke_point_replayer_if.sv | 35 +++
 rtl/stroke_point_replayer.sv | 143 ++++++++++++++
 tb/tb_stroke_point_replayer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/stroke_point_replayer_if.sv
// Capture-side inputs and replay-stream outputs of stroke_point_replayer.
// The slave modport is the replayer, the master modport is whoever drives the capture side.
interface stroke_point_replayer_if #(
  parameter int CW = 5,
  parameter int AW = 6
);
  logic          i_pt_valid;
  logic [CW-1:0] i_pt_x;
  logic [CW-1:0] i_pt_y;
  logic          i_stroke_end;
  logic [19:0]   i_total_length;

  logic          o_valid;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_pass;
  logic          o_pass_start;
  logic [19:0]   o_cum_length;
  logic          o_busy;
  logic          o_done;
  logic          o_overflow;
  logic [AW:0]   o_count;

  modport master (
    output i_pt_valid, i_pt_x, i_pt_y, i_stroke_end, i_total_length,
    input  o_valid, o_x, o_y, o_pass, o_pass_start, o_cum_length,
           o_busy, o_done, o_overflow, o_count
  );

  modport slave (
    input  i_pt_valid, i_pt_x, i_pt_y, i_stroke_end, i_total_length,
    output o_valid, o_x, o_y, o_pass, o_pass_start, o_cum_length,
           o_busy, o_done, o_overflow, o_count
  );
endinterface

// File: rtl/stroke_point_replayer.sv
// Captures one stroke of (x,y) points, then replays it twice: length pass, then resample pass.
// Optional REPLAY_DEDUP_EN drops a captured point identical to the previously stored one.
module stroke_point_replayer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CW    = 5
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  stroke_point_replayer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_START1, S_PASS1, S_LATCH, S_START2, S_PASS2, S_DONE
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t        state, state_nx;
  logic [CW-1:0] mem_x [DEPTH];
  logic [CW-1:0] mem_y [DEPTH];
  logic [AW:0]   count;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_addr;
  logic [CW-1:0] rd_x, rd_y;
  logic          overflow;
  logic [19:0]   cum_length;
  logic          dup;
  logic          store_first, store_next, drop_full, load_rd;
  logic [AW-1:0] wr_addr;

`ifdef REPLAY_DEDUP_EN
  logic [CW-1:0] last_x, last_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_x <= '0;
      last_y <= '0;
    end else if (store_first || store_next) begin
      last_x <= bus.i_pt_x;
      last_y <= bus.i_pt_y;
    end
  end

  assign dup = (bus.i_pt_x == last_x) && (bus.i_pt_y == last_y);
`else
  assign dup = 1'b0;
`endif

  // Each pass starts its read at address 0; the START state preloads point 0.
  assign rd_addr = (state == S_START1 || state == S_START2) ? '0 : rd_ptr;
  assign wr_addr = store_first ? '0 : count[AW-1:0];

  always_comb begin
    state_nx    = state;
    store_first = 1'b0;
    store_next  = 1'b0;
    drop_full   = 1'b0;
    load_rd     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_pt_valid) begin
          store_first = 1'b1;
          state_nx    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (bus.i_pt_valid && !dup) begin
          if (count == FULL) drop_full  = 1'b1;
          else               store_next = 1'b1;
        end
        if (bus.i_stroke_end) state_nx = S_START1;
      end
      S_START1: begin
        load_rd  = 1'b1;
        state_nx = S_PASS1;
      end
      S_PASS1: begin
        if (rd_ptr < count) load_rd  = 1'b1;
        else                state_nx = S_LATCH;
      end
      S_LATCH:  state_nx = S_START2;
      S_START2: begin
        load_rd  = 1'b1;
        state_nx = S_PASS2;
      end
      S_PASS2: begin
        if (rd_ptr < count) load_rd  = 1'b1;
        else                state_nx = S_DONE;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (store_first || store_next) begin
      mem_x[wr_addr] <= bus.i_pt_x;
      mem_y[wr_addr] <= bus.i_pt_y;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      rd_x       <= '0;
      rd_y       <= '0;
      overflow   <= 1'b0;
      cum_length <= '0;
    end else begin
      state <= state_nx;
      if (store_first) begin
        count    <= ONE;
        overflow <= 1'b0;
      end else if (store_next) begin
        count <= count + ONE;
      end
      if (drop_full) overflow <= 1'b1;
      // Registered read: the loaded point is presented alongside o_valid next cycle.
      if (load_rd) begin
        rd_x   <= mem_x[rd_addr[AW-1:0]];
        rd_y   <= mem_y[rd_addr[AW-1:0]];
        rd_ptr <= rd_addr + ONE;
      end
      if (state == S_LATCH) cum_length <= bus.i_total_length;
    end
  end

  assign bus.o_valid      = (state == S_PASS1) || (state == S_PASS2);
  assign bus.o_pass       = (state == S_START2) || (state == S_PASS2);
  assign bus.o_pass_start = (state == S_START1) || (state == S_START2);
  assign bus.o_busy       = (state != S_IDLE) && (state != S_CAPTURE);
  assign bus.o_done       = (state == S_DONE);
  assign bus.o_x          = rd_x;
  assign bus.o_y          = rd_y;
  assign bus.o_cum_length = cum_length;
  assign bus.o_overflow   = overflow;
  assign bus.o_count      = count;

endmodule

// File: tb/tb_stroke_point_replayer.sv
// Directed bench for stroke_point_replayer: capture, double replay timing, overflow,
// ignored inputs while busy, mid-pass reset. Honors REPLAY_DEDUP_EN for the duplicate-point stroke.
module tb_stroke_point_replayer;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 5;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   exp_x [70];
  int   exp_y [70];
  int   n1;

  always #5 i_clk = ~i_clk;

  stroke_point_replayer_if #(.CW(CW), .AW(AW)) bus ();

  stroke_point_replayer #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic send_point(input int x, input int y);
    bus.i_pt_valid = 1'b1;
    bus.i_pt_x     = CW'(x);
    bus.i_pt_y     = CW'(y);
    step();
    bus.i_pt_valid = 1'b0;
  endtask

  task automatic end_stroke();
    bus.i_stroke_end = 1'b1;
    step();
    bus.i_stroke_end = 1'b0;
  endtask

  // Entered one cycle after the stroke-end edge (START1 expected); leaves one cycle after DONE.
  task automatic run_replay(input string tag, input int n, input int tl, input bit inject, input bit ovf);
    int busy_cyc = 0;
    check({tag, "_start1"}, 32'(bus.o_pass_start), 1);
    check({tag, "_start1_pass"}, 32'(bus.o_pass), 0);
    busy_cyc += int'(bus.o_busy);
    if (inject) begin
      bus.i_pt_valid   = 1'b1;
      bus.i_pt_x       = 5'd31;
      bus.i_pt_y       = 5'd31;
      bus.i_stroke_end = 1'b1;
    end
    step();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_p1_valid%0d", tag, i), 32'(bus.o_valid), 1);
      check($sformatf("%s_p1_x%0d", tag, i), 32'(bus.o_x), exp_x[i]);
      check($sformatf("%s_p1_y%0d", tag, i), 32'(bus.o_y), exp_y[i]);
      check($sformatf("%s_p1_pass%0d", tag, i), 32'(bus.o_pass), 0);
      busy_cyc += int'(bus.o_busy);
      step();
    end
    bus.i_pt_valid   = 1'b0;
    bus.i_stroke_end = 1'b0;
    check({tag, "_latch_valid"}, 32'(bus.o_valid), 0);
    check({tag, "_latch_hold_x"}, 32'(bus.o_x), exp_x[n-1]);
    busy_cyc += int'(bus.o_busy);
    bus.i_total_length = 20'(tl);
    step();
    check({tag, "_start2"}, 32'(bus.o_pass_start), 1);
    check({tag, "_start2_pass"}, 32'(bus.o_pass), 1);
    busy_cyc += int'(bus.o_busy);
    step();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_p2_valid%0d", tag, i), 32'(bus.o_valid), 1);
      check($sformatf("%s_p2_x%0d", tag, i), 32'(bus.o_x), exp_x[i]);
      check($sformatf("%s_p2_y%0d", tag, i), 32'(bus.o_y), exp_y[i]);
      check($sformatf("%s_p2_pass%0d", tag, i), 32'(bus.o_pass), 1);
      check($sformatf("%s_p2_cum%0d", tag, i), 32'(bus.o_cum_length), tl);
      busy_cyc += int'(bus.o_busy);
      if (i == 0) bus.i_total_length = 20'(tl + 1);
      step();
    end
    check({tag, "_done"}, 32'(bus.o_done), 1);
    check({tag, "_done_valid"}, 32'(bus.o_valid), 0);
    busy_cyc += int'(bus.o_busy);
    step();
    check({tag, "_after_done"}, 32'(bus.o_done), 0);
    check({tag, "_after_busy"}, 32'(bus.o_busy), 0);
    check({tag, "_cum_hold"}, 32'(bus.o_cum_length), tl);
    check({tag, "_count"}, 32'(bus.o_count), n);
    check({tag, "_overflow"}, 32'(bus.o_overflow), 32'(ovf));
    check({tag, "_busy_cycles"}, busy_cyc, 2 * n + 4);
  endtask

  initial begin
    bus.i_pt_valid     = 1'b0;
    bus.i_pt_x         = '0;
    bus.i_pt_y         = '0;
    bus.i_stroke_end   = 1'b0;
    bus.i_total_length = '0;
    $display("[TB] start");

    #12;
    check("rst_valid", 32'(bus.o_valid), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_done", 32'(bus.o_done), 0);
    check("rst_count", 32'(bus.o_count), 0);
    check("rst_overflow", 32'(bus.o_overflow), 0);
    check("rst_cum", 32'(bus.o_cum_length), 0);
    step();
    i_rst_n = 1'b1;
    step();

    // Stroke end with nothing captured must not start a replay.
    end_stroke();
    check("idle_end_busy", 32'(bus.o_busy), 0);
    step();
    check("idle_end_busy2", 32'(bus.o_busy), 0);

    $display("[TB] three-point stroke with repeated point");
    exp_x[0] = 1; exp_y[0] = 2;
    exp_x[1] = 4; exp_y[1] = 6;
    exp_x[2] = 4; exp_y[2] = 6;
`ifdef REPLAY_DEDUP_EN
    n1 = 2;
`else
    n1 = 3;
`endif
    send_point(1, 2);
    send_point(4, 6);
    send_point(4, 6);
    check("t1_count_pre", 32'(bus.o_count), n1);
    end_stroke();
    run_replay("t1", n1, 50, 1'b0, 1'b0);

    $display("[TB] seventy-point stroke into depth 64");
    for (int i = 0; i < 70; i++) begin
      exp_x[i] = i % 32;
      exp_y[i] = (3 * i + 1) % 32;
      send_point(exp_x[i], exp_y[i]);
    end
    check("t2_overflow_pre", 32'(bus.o_overflow), 1);
    check("t2_count_pre", 32'(bus.o_count), 64);
    end_stroke();
    run_replay("t2", 64, 1000, 1'b0, 1'b1);

    $display("[TB] fifth point together with stroke end");
    for (int i = 0; i < 5; i++) begin
      exp_x[i] = 10 + i;
      exp_y[i] = 20 - i;
    end
    send_point(exp_x[0], exp_y[0]);
    check("t3_overflow_cleared", 32'(bus.o_overflow), 0);
    check("t3_count_first", 32'(bus.o_count), 1);
    for (int i = 1; i < 4; i++) send_point(exp_x[i], exp_y[i]);
    bus.i_pt_valid   = 1'b1;
    bus.i_pt_x       = CW'(exp_x[4]);
    bus.i_pt_y       = CW'(exp_y[4]);
    bus.i_stroke_end = 1'b1;
    step();
    bus.i_pt_valid   = 1'b0;
    bus.i_stroke_end = 1'b0;
    run_replay("t3", 5, 300, 1'b0, 1'b0);

    $display("[TB] inputs during pass 1 are ignored");
    exp_x[0] = 3;  exp_y[0] = 17;
    exp_x[1] = 8;  exp_y[1] = 0;
    exp_x[2] = 30; exp_y[2] = 12;
    exp_x[3] = 5;  exp_y[3] = 5;
    for (int i = 0; i < 4; i++) send_point(exp_x[i], exp_y[i]);
    end_stroke();
    run_replay("t4", 4, 77, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_idle_busy%0d", i), 32'(bus.o_busy), 0);
      check($sformatf("t4_idle_valid%0d", i), 32'(bus.o_valid), 0);
      step();
    end
    check("t4_count_kept", 32'(bus.o_count), 4);

    $display("[TB] single-point stroke");
    exp_x[0] = 7; exp_y[0] = 9;
    send_point(7, 9);
    check("t6_overflow", 32'(bus.o_overflow), 0);
    end_stroke();
    run_replay("t6", 1, 5, 1'b0, 1'b0);

    $display("[TB] reset in the middle of pass 2");
    exp_x[0] = 2; exp_y[0] = 3;
    exp_x[1] = 5; exp_y[1] = 5;
    exp_x[2] = 8; exp_y[2] = 1;
    for (int i = 0; i < 3; i++) send_point(exp_x[i], exp_y[i]);
    end_stroke();
    repeat (7) step();
    check("t5_pre_valid", 32'(bus.o_valid), 1);
    check("t5_pre_pass", 32'(bus.o_pass), 1);
    check("t5_pre_x", 32'(bus.o_x), exp_x[1]);
    i_rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(bus.o_valid), 0);
    check("t5_rst_pass", 32'(bus.o_pass), 0);
    check("t5_rst_busy", 32'(bus.o_busy), 0);
    check("t5_rst_done", 32'(bus.o_done), 0);
    check("t5_rst_x", 32'(bus.o_x), 0);
    check("t5_rst_y", 32'(bus.o_y), 0);
    check("t5_rst_count", 32'(bus.o_count), 0);
    check("t5_rst_cum", 32'(bus.o_cum_length), 0);
    step();
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5_no_done%0d", i), 32'(bus.o_done), 0);
      check($sformatf("t5_idle_busy%0d", i), 32'(bus.o_busy), 0);
    end
    exp_x[0] = 6; exp_y[0] = 1;
    exp_x[1] = 9; exp_y[1] = 30;
    send_point(6, 1);
    send_point(9, 30);
    end_stroke();
    run_replay("t5", 2, 33, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
